// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - memory-stage request/response bundle between CPU and data-memory responder
interface data_mem_responder_if #(
    parameter int N = 32
) ();
    logic         MemEn0;
    logic         MemWrEn0;
    logic [N-1:0] MemAddr0;
    logic [N-1:0] MemDataIn;
    logic [N-1:0] MemOut;
    logic         Valid;
    logic         Busy;
    logic         Err;

    modport master (
        output MemEn0, MemWrEn0, MemAddr0, MemDataIn,
        input  MemOut, Valid, Busy, Err
    );

    modport slave (
        input  MemEn0, MemWrEn0, MemAddr0, MemDataIn,
        output MemOut, Valid, Busy, Err
    );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency data-memory responder with alignment/range error reporting
module data_mem_responder #(
    parameter int N       = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_mem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [N:0] BYTE_LIMIT = (N+1)'(DEPTH * 4);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [N-1:0] mem [DEPTH];

    logic [1:0]   state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [N-1:0] addr_q, addr_d;
    logic         wr_q, wr_d;
    logic [N-1:0] data_q, data_d;
    logic         err_q, err_d;
    logic [N-1:0] mem_out_q, mem_out_d;

    logic         commit;
    logic         c_wr;
    logic [N-1:0] c_addr;
    logic [N-1:0] c_data;
    logic [AW-1:0] c_idx;
    logic         c_bad;
    logic         mem_we;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        data_d    = data_q;
        err_d     = err_q;
        mem_out_d = mem_out_q;
        commit    = 1'b0;
        c_wr      = wr_q;
        c_addr    = addr_q;
        c_data    = data_q;
        mem_we    = 1'b0;

        case (state_q)
            S_IDLE, S_RESP: begin
                if (bus.MemEn0) begin
                    addr_d = bus.MemAddr0;
                    wr_d   = bus.MemWrEn0;
                    data_d = bus.MemDataIn;
                    cnt_d  = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        // Single-cycle build commits straight from the bus on the accept edge.
                        state_d = S_RESP;
                        commit  = 1'b1;
                        c_wr    = bus.MemWrEn0;
                        c_addr  = bus.MemAddr0;
                        c_data  = bus.MemDataIn;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // Leaving at cnt==1 lets RESP double as the next accept cycle,
                // giving one access every LATENCY cycles back-to-back.
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        c_idx = c_addr[AW+1:2];
        c_bad = (c_addr[1:0] != 2'b00) || ({1'b0, c_addr} >= BYTE_LIMIT);

        if (commit) begin
            err_d  = c_bad;
            mem_we = !c_bad && c_wr;
            if (c_bad || c_wr) begin
                mem_out_d = '0;
            end else begin
                mem_out_d = mem[c_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            data_q    <= '0;
            err_q     <= 1'b0;
            mem_out_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            data_q    <= data_d;
            err_q     <= err_d;
            mem_out_q <= mem_out_d;
        end
    end

    // Storage is deliberately not reset; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we && rst_n) begin
            mem[c_idx] <= c_data;
        end
    end

    assign bus.Valid  = (state_q == S_RESP);
    assign bus.Busy   = (state_q == S_WAIT);
    assign bus.Err    = (state_q == S_RESP) && err_q;
    assign bus.MemOut = mem_out_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder (LATENCY=4 and LATENCY=1 builds)
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_responder_if #(.N(32)) bus4 ();
    data_mem_responder_if #(.N(32)) bus1 ();

    data_mem_responder #(.N(32), .DEPTH(1024), .LATENCY(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4)
    );
    data_mem_responder #(.N(32), .DEPTH(64), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    req_t q[$];
    logic [31:0] ref4 [int];
    logic [31:0] ref1 [int];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: a word store addressed by byte address / 4, with range and alignment rules.
    function automatic void model(input int which, input req_t r,
                                  output bit err, output logic [31:0] out, output bit known);
        int depth = (which == 1) ? 64 : 1024;
        int idx = int'(r.addr >> 2);
        err = (r.addr % 4 != 0) || (r.addr >= 32'(depth * 4));
        out = 32'h0;
        known = 1'b1;
        if (!err) begin
            if (r.wr) begin
                if (which == 1) ref1[idx] = r.data; else ref4[idx] = r.data;
            end else if (which == 1) begin
                if (ref1.exists(idx)) out = ref1[idx]; else known = 1'b0;
            end else begin
                if (ref4.exists(idx)) out = ref4[idx]; else known = 1'b0;
            end
        end
    endfunction

    function automatic req_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        req_t r;
        r.wr = wr; r.addr = addr; r.data = data;
        return r;
    endfunction

    task automatic drive4(input req_t r);
        bus4.MemEn0 = 1'b1; bus4.MemWrEn0 = r.wr; bus4.MemAddr0 = r.addr; bus4.MemDataIn = r.data;
    endtask

    task automatic drive1(input req_t r);
        bus1.MemEn0 = 1'b1; bus1.MemWrEn0 = r.wr; bus1.MemAddr0 = r.addr; bus1.MemDataIn = r.data;
    endtask

    // Runs the queued requests back-to-back on the LATENCY=4 instance; call at a negedge while idle.
    task automatic run_seq(input bit scramble);
        int cyc;
        bit err;
        logic [31:0] out;
        bit known;
        drive4(q[0]);
        for (int i = 0; i < q.size(); i++) begin
            model(0, q[i], err, out, known);
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
                if (cyc == 1) check("busy_wait", bus4.Busy, 1);
                if (!bus4.Valid && scramble) begin
                    bus4.MemEn0 = 1'($urandom); bus4.MemWrEn0 = 1'($urandom);
                    bus4.MemAddr0 = $urandom; bus4.MemDataIn = $urandom;
                end
            end while (!bus4.Valid && cyc < 40);
            check("latency", 64'(cyc), 64'd4);
            check("err", bus4.Err, err);
            if (known) check("memout", bus4.MemOut, out);
            if (i + 1 < q.size()) drive4(q[i + 1]);
            else bus4.MemEn0 = 1'b0;
        end
        @(negedge clk);
        check("valid_pulse", bus4.Valid, 0);
        check("err_idle", bus4.Err, 0);
        q.delete();
    endtask

    initial begin
        int vcount;
        bit err;
        logic [31:0] out;
        bit known;
        logic [31:0] pool [17];

        bus4.MemEn0 = 0; bus4.MemWrEn0 = 0; bus4.MemAddr0 = 0; bus4.MemDataIn = 0;
        bus1.MemEn0 = 0; bus1.MemWrEn0 = 0; bus1.MemAddr0 = 0; bus1.MemDataIn = 0;
        repeat (2) @(negedge clk);
        check("rst_valid", bus4.Valid, 0);
        check("rst_busy", bus4.Busy, 0);
        check("rst_err", bus4.Err, 0);
        check("rst_memout", bus4.MemOut, 0);
        check("rst_valid1", bus1.Valid, 0);
        check("rst_memout1", bus1.MemOut, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) pool[i] = 32'(i * 4);
        pool[16] = 32'(1023 * 4);
        for (int i = 0; i < 17; i++) q.push_back(mk(1, pool[i], $urandom));
        run_seq(0);

        // Write then read, single requests
        q.push_back(mk(1, 32'h10, 32'hDEADBEEF)); run_seq(0);
        q.push_back(mk(0, 32'h10, 32'h0)); run_seq(0);
        // Misaligned and out of range, then confirm array untouched
        q.push_back(mk(1, 32'h12, 32'h12345678)); run_seq(0);
        q.push_back(mk(0, 32'h12, 32'h0)); run_seq(0);
        q.push_back(mk(1, 32'h1000, 32'h87654321)); run_seq(0);
        q.push_back(mk(0, 32'h10, 32'h0)); run_seq(0);
        // Back-to-back write/read/read
        q.push_back(mk(1, 32'h20, 32'h1));
        q.push_back(mk(0, 32'h20, 32'h0));
        q.push_back(mk(0, 32'h24, 32'h0));
        run_seq(0);
        // Inputs wiggled while waiting
        q.push_back(mk(1, 32'h14, 32'hCAFEF00D));
        q.push_back(mk(0, 32'h14, 32'h0));
        run_seq(1);

        // Reset two cycles into a write
        q.push_back(mk(1, 32'h30, 32'hA5A50030)); run_seq(0);
        drive4(mk(1, 32'h30, 32'h55));
        repeat (2) @(negedge clk);
        bus4.MemEn0 = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", bus4.Valid, 0);
        check("rst_mid_busy", bus4.Busy, 0);
        check("rst_mid_memout", bus4.MemOut, 0);
        @(negedge clk);
        rst_n = 1'b1;
        vcount = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus4.Valid) vcount++;
        end
        check("no_valid_after_rst", 64'(vcount), 64'd0);
        q.push_back(mk(0, 32'h30, 32'h0)); run_seq(0);

        // Randomized batches
        repeat (12) begin
            int n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) begin
                int kind = $urandom_range(0, 9);
                logic [31:0] a = pool[$urandom_range(0, 16)];
                if (kind == 0) a = a + 32'($urandom_range(1, 3));
                else if (kind == 1) a = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFC : 32'h1000 + 32'(4 * $urandom_range(0, 7));
                q.push_back(mk(1'($urandom), a, $urandom));
            end
            run_seq(1'($urandom));
        end

        // LATENCY=1 build: one response per cycle while requests are sustained
        q.push_back(mk(1, 32'h0, $urandom));
        q.push_back(mk(0, 32'h0, 32'h0));
        q.push_back(mk(1, 32'h4, $urandom));
        q.push_back(mk(0, 32'h4, 32'h0));
        q.push_back(mk(0, 32'h100, 32'h0));
        q.push_back(mk(0, 32'h2, 32'h0));
        q.push_back(mk(0, 32'hFC, 32'h0));
        q.push_back(mk(0, 32'h0, 32'h0));
        drive1(q[0]);
        for (int i = 0; i < q.size(); i++) begin
            model(1, q[i], err, out, known);
            @(negedge clk);
            check("l1_valid", bus1.Valid, 1);
            check("l1_busy", bus1.Busy, 0);
            check("l1_err", bus1.Err, err);
            if (known) check("l1_memout", bus1.MemOut, out);
            if (i + 1 < q.size()) drive1(q[i + 1]);
            else bus1.MemEn0 = 1'b0;
        end
        @(negedge clk);
        check("l1_valid_end", bus1.Valid, 0);
        q.delete();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
